// File: rtl/loader_pkg.sv
// Shared state encoding, stream constants and address helper for the instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
        CHK   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } loaderState_e;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;

    // Byte address of a word slot; wraps modulo 2^32.
    function automatic logic [31:0] wordAddr(input logic [31:0] base, input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/word_packer.sv
// Little-endian byte-to-word packer: every fourth accepted byte completes a 32-bit word.
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byteValid,
    input  logic [7:0]  byteIn,
    output logic        wordComplete,
    output logic [31:0] word
);

    logic [1:0]  byteCntQ;
    logic [23:0] shiftQ;  // three most recent bytes, oldest in the low byte

    assign wordComplete = byteValid && (byteCntQ == 2'(WORD_BYTES - 1));
    assign word         = {byteIn, shiftQ};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byteCntQ <= '0;
            shiftQ   <= '0;
        end else if (clear) begin
            byteCntQ <= '0;
            shiftQ   <= '0;
        end else if (byteValid) begin
            byteCntQ <= byteCntQ + 2'd1;
            shiftQ   <= {byteIn, shiftQ[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: writes a counted byte stream into instruction memory and holds the core in reset
// until the image is complete. Define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte.
module imem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        reload,
    output logic        InstrWrite,
    output logic [31:0] WriteInst,
    output logic [31:0] WriteAdress,
    output logic        core_reset,
    output logic        done,
    output logic        err
);

`ifdef LOADER_CHECKSUM_EN
    localparam loaderState_e TAIL_STATE = CHK;
`else
    localparam loaderState_e TAIL_STATE = DONE;
`endif

    loaderState_e stateQ, stateD;
    logic         hdrCntQ;
    logic [7:0]   countLoQ;
    logic [15:0]  countQ;
    logic [15:0]  wordIdxQ;
    logic [31:0]  instQ;
    logic [31:0]  addrQ;
    logic         accept, dataAccept, restart, lastWord, wordComplete;
    logic [15:0]  hdrCount;
    logic [31:0]  packedWord;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]   xorQ;
`endif

    assign rx_ready   = (stateQ == HDR) || (stateQ == DATA) || (stateQ == CHK);
    assign accept     = rx_valid && rx_ready;
    assign dataAccept = accept && (stateQ == DATA);
    assign restart    = reload && ((stateQ == DONE) || (stateQ == ERR));
    assign hdrCount   = {rx_data, countLoQ};
    assign lastWord   = (wordIdxQ + 16'd1) == countQ;

    assign InstrWrite  = stateQ == WRITE;
    assign WriteInst   = instQ;
    assign WriteAdress = addrQ;
    assign done        = stateQ == DONE;
    assign err         = stateQ == ERR;
    assign core_reset  = stateQ != DONE;

    word_packer uPacker (
        .clk          (clk),
        .reset        (reset),
        .clear        (restart),
        .byteValid    (dataAccept),
        .byteIn       (rx_data),
        .wordComplete (wordComplete),
        .word         (packedWord)
    );

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            HDR: begin
                if (accept && hdrCntQ == 1'(HDR_BYTES - 1)) begin
                    if (32'(hdrCount) > MAX_WORDS) stateD = ERR;
                    else if (hdrCount == 16'd0)    stateD = TAIL_STATE;
                    else                           stateD = DATA;
                end
            end
            DATA:  if (wordComplete) stateD = WRITE;
            WRITE: stateD = lastWord ? TAIL_STATE : DATA;
`ifdef LOADER_CHECKSUM_EN
            CHK:   if (accept) stateD = (rx_data == xorQ) ? DONE : ERR;
`endif
            DONE, ERR: if (reload) stateD = HDR;
            default: stateD = HDR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ   <= HDR;
            hdrCntQ  <= 1'b0;
            countLoQ <= '0;
            countQ   <= '0;
            wordIdxQ <= '0;
            instQ    <= '0;
            addrQ    <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            xorQ     <= '0;
`endif
        end else begin
            stateQ <= stateD;
            if (restart) begin
                hdrCntQ  <= 1'b0;
                wordIdxQ <= '0;
`ifdef LOADER_CHECKSUM_EN
                xorQ     <= '0;
`endif
            end
            if (accept && stateQ == HDR) begin
                if (hdrCntQ == 1'(HDR_BYTES - 1)) begin
                    countQ  <= hdrCount;
                    hdrCntQ <= 1'b0;
                end else begin
                    countLoQ <= rx_data;
                    hdrCntQ  <= 1'b1;
                end
            end
            // Word and address are captured with the 4th byte so they are stable during WRITE.
            if (wordComplete) begin
                instQ <= packedWord;
                addrQ <= wordAddr(BASE_ADDR, wordIdxQ);
            end
            if (stateQ == WRITE) wordIdxQ <= wordIdxQ + 16'd1;
`ifdef LOADER_CHECKSUM_EN
            if (accept && (stateQ == HDR || stateQ == DATA)) xorQ <= xorQ ^ rx_data;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed vectors, reset/reload sequences and a randomized
// load soak checked against a stream-level reference model.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 64;
`ifdef LOADER_CHECKSUM_EN
    localparam int CKB = 1;
`else
    localparam int CKB = 0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        int          nb;
        logic [7:0]  b[12];
        int          gap;
        int          nWr;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        ok;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic        reload = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, InstrWrite, core_reset, done, err;
    logic [31:0] WriteInst, WriteAdress;

    int   compared = 0;
    int   mismatched = 0;
    wr_t  wrQ[$];
    wr_t  expQ[$];
    logic expDone;
    int   expUsed;

    imem_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .reload      (reload),
        .InstrWrite  (InstrWrite),
        .WriteInst   (WriteInst),
        .WriteAdress (WriteAdress),
        .core_reset  (core_reset),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && InstrWrite === 1'b1) begin
            wrQ.push_back({WriteAdress, WriteInst});
            chk("ready_in_write", 32'(rx_ready), 32'd0);
        end
    end

    task automatic checkResetOutputs(input string tag);
        chk({tag, ".InstrWrite"}, 32'(InstrWrite), 32'd0);
        chk({tag, ".WriteInst"}, WriteInst, 32'd0);
        chk({tag, ".WriteAdress"}, WriteAdress, BASE);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".err"}, 32'(err), 32'd0);
        chk({tag, ".core_reset"}, 32'(core_reset), 32'd1);
    endtask

    task automatic applyReset(input string tag);
        rx_valid = 1'b0;
        reload   = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1 checkResetOutputs(tag);
        @(negedge clk);
        reset = 1'b1;
        chk({tag, ".ready_after_reset"}, 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1 wrQ.delete();
    endtask

    task automatic reloadPulse(input string tag);
        @(posedge clk);
        #1 reload = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
        chk({tag, ".core_reset"}, 32'(core_reset), 32'd1);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".err"}, 32'(err), 32'd0);
        chk({tag, ".rx_ready"}, 32'(rx_ready), 32'd1);
        wrQ.delete();
    endtask

    // Gaps carry garbage data and stray reload pulses, neither of which may be consumed.
    task automatic sendByte(input logic [7:0] b, input int gap);
        int n;
        bit acc;
        repeat (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            reload   = ($urandom_range(0, 5) == 0);
            @(posedge clk);
            #1;
        end
        reload   = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1 n++;
        end
        rx_valid = 1'b0;
        if (!acc) chk("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic sendStream(input bq_t s, input int n, input int gmin, input int gmax);
        for (int i = 0; i < n; i++) sendByte(s[i], $urandom_range(gmax, gmin));
    endtask

    task automatic waitEnd(input string tag);
        int n = 0;
        while (done !== 1'b1 && err !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk({tag, ".finish_timeout"}, 32'(n), 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic checkResult(input string tag, input wr_t want[$], input logic ok);
        chk({tag, ".writes"}, 32'(wrQ.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < wrQ.size(); i++) begin
            chk($sformatf("%s.addr%0d", tag, i), wrQ[i].addr, want[i].addr);
            chk($sformatf("%s.data%0d", tag, i), wrQ[i].data, want[i].data);
        end
        chk({tag, ".done"}, 32'(done), 32'(ok));
        chk({tag, ".err"}, 32'(err), 32'(!ok));
        chk({tag, ".core_reset"}, 32'(core_reset), 32'(!ok));
        chk({tag, ".rx_ready"}, 32'(rx_ready), 32'd0);
    endtask

    // Stream-level model: header count, little-endian words at consecutive addresses, XOR trailer.
    task automatic refModel(input bq_t s);
        int cnt;
        logic [31:0] w;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
`endif
        expQ.delete();
        cnt = int'({s[1], s[0]});
        if (cnt > MAXW) begin
            expDone = 1'b0;
            expUsed = 2;
            return;
        end
        for (int i = 0; i < cnt; i++) begin
            w = {s[2 + 4 * i + 3], s[2 + 4 * i + 2], s[2 + 4 * i + 1], s[2 + 4 * i]};
            expQ.push_back({BASE + 32'(4 * i), w});
        end
        expUsed = 2 + 4 * cnt;
`ifdef LOADER_CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < expUsed; i++) x ^= s[i];
        expDone = (s[expUsed] == x);
        expUsed++;
`else
        expDone = 1'b1;
`endif
    endtask

    initial begin
        vec_t v;
        vec_t vecs[$];
        bq_t  s;
        wr_t  want[$];
        string tag;

        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t vecs[$];
        bq_t  s;
        wr_t  want[$];
        string tag;
        int cnt;
        int r;
        logic [7:0] x;

        // Table of fixed vectors with hand-derived expectations.
        v.b = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC3, 8'h00};
        v.nb = 10 + CKB; v.gap = 0; v.nWr = 2; v.d0 = 32'h0050_0093; v.d1 = 32'h0010_0113;
        v.ok = 1'b1;
        vecs.push_back(v);
        v.gap = 3;
        vecs.push_back(v);
        v.b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        v.nb = 2 + CKB; v.gap = 0; v.nWr = 0; v.ok = 1'b1;
        vecs.push_back(v);
        v.b[0] = 8'h41; v.nb = 2; v.ok = 1'b0;
        vecs.push_back(v);
        v.b[0] = 8'h00; v.b[1] = 8'h01;
        vecs.push_back(v);
        v.b = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        v.nb = 6 + CKB; v.gap = 1; v.nWr = 1; v.d0 = 32'h0000_0013; v.ok = 1'b1;
        vecs.push_back(v);
`ifdef LOADER_CHECKSUM_EN
        v.b = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC4, 8'h00};
        v.nb = 11; v.gap = 0; v.nWr = 2; v.d0 = 32'h0050_0093; v.d1 = 32'h0010_0113;
        v.ok = 1'b0;
        vecs.push_back(v);
`endif

        for (int k = 0; k < vecs.size(); k++) begin
            tag = $sformatf("vec%0d", k);
            applyReset({tag, ".reset"});
            s = {};
            for (int i = 0; i < vecs[k].nb; i++) s.push_back(vecs[k].b[i]);
            sendStream(s, vecs[k].nb, vecs[k].gap, vecs[k].gap);
            if (!vecs[k].ok) begin
                chk({tag, ".err_immediate"}, 32'(err), 32'd1);
                chk({tag, ".ready_immediate"}, 32'(rx_ready), 32'd0);
            end
            waitEnd(tag);
            want = {};
            if (vecs[k].nWr > 0) want.push_back({BASE, vecs[k].d0});
            if (vecs[k].nWr > 1) want.push_back({BASE + 32'd4, vecs[k].d1});
            checkResult(tag, want, vecs[k].ok);
        end

        // Asynchronous reset after six bytes, then the full image again.
        applyReset("mid.reset0");
        s = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC3};
        sendStream(s, 6, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("mid.first_write", 32'(wrQ.size()), 32'd1);
        #1 reset = 1'b0;
        #1 checkResetOutputs("mid.async");
        @(negedge clk);
        reset = 1'b1;
        chk("mid.ready_after_reset", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1 wrQ.delete();
        sendStream(s, 10 + CKB, 0, 2);
        waitEnd("mid");
        want = {};
        want.push_back({BASE, 32'h0050_0093});
        want.push_back({BASE + 32'd4, 32'h0010_0113});
        checkResult("mid", want, 1'b1);

        // Reload from DONE and load a one-word image.
        reloadPulse("rl.pulse");
        s = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
        sendStream(s, 6 + CKB, 0, 0);
        waitEnd("rl");
        want = {};
        want.push_back({BASE, 32'h0000_0013});
        checkResult("rl", want, 1'b1);

        // Randomized loads against the reference model.
        for (int it = 0; it < 25; it++) begin
            tag = $sformatf("rnd%0d", it);
            if ($urandom_range(0, 1) == 1) reloadPulse({tag, ".reload"});
            else applyReset({tag, ".reset"});
            r = $urandom_range(0, 9);
            if (r == 0)      cnt = 65 + $urandom_range(0, 500);
            else if (r == 1) cnt = 64;
            else if (r == 2) cnt = 0;
            else             cnt = $urandom_range(1, 6);
            s = {};
            s.push_back(8'(cnt));
            s.push_back(8'(cnt >> 8));
            if (cnt <= MAXW) begin
                for (int i = 0; i < 4 * cnt; i++) s.push_back(8'($urandom));
                x = 8'h00;
                foreach (s[i]) x ^= s[i];
                if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
                s.push_back(x);
            end
            refModel(s);
            sendStream(s, expUsed, 0, 3);
            if (!expDone) chk({tag, ".err_immediate"}, 32'(err), 32'd1);
            waitEnd(tag);
            checkResult(tag, expQ, expDone);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction loader that sits directly upstream of the pipelined core top and drives its instruction-memory write port (InstrWrite / WriteInst / WriteAdress). It receives a byte stream over a valid/ready handshake and packs it into 32-bit little-endian words. It writes each word into instruction memory at consecutive word addresses and holds the core in reset until the image is complete. A reload request restarts the load without a global reset.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of the first instruction word
- MAX_WORDS, 64: instruction-memory depth in words; larger images are rejected
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- rx_data  input  8  incoming image byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts a byte; transfer occurs when rx_valid & rx_ready at a rising edge
- reload  input  1  single-cycle request to restart loading; honoured only in DONE or ERR
- InstrWrite  output  1  instruction-memory write strobe, one cycle per word
- WriteInst  output  32  instruction word
- WriteAdress  output  32  byte address, BASE_ADDR + 4*word_index
- core_reset  output  1  active-high reset to the core; high while loading or in error
- done  output  1  image loaded, core running
- err  output  1  load rejected

## Operation
- Stream format:
  - count_lo, count_hi: 16-bit word count
  - count×4 data bytes, least-significant byte first
  - checksum byte, only with the configuration macro
- States:
  - HDR: rx_ready=1; collects 2 count bytes.
    - After count_hi: if count > MAX_WORDS → ERR.
    - Else if count == 0 → CHK (macro) or DONE.
    - Else → DATA.
  - DATA: rx_ready=1; shifts bytes into a word; after the 4th byte → WRITE.
  - WRITE: rx_ready=0; InstrWrite=1 for exactly one cycle; word_index increments.
    - → DATA if words remain.
    - Else → CHK (macro) or DONE.
  - CHK: rx_ready=1; one byte. Equal to the running XOR → DONE, else → ERR.
  - DONE: rx_ready=0, done=1, core_reset=0.
  - ERR: rx_ready=0, err=1, core_reset=1.
- reload in DONE/ERR → HDR; clears word_index, byte counter, checksum, done and err; core_reset=1. reload in HDR/DATA/WRITE/CHK is ignored.
- Arithmetic:
  - word_index is 16 bits.
  - WriteAdress = BASE_ADDR + {word_index, 2'b00}, 32-bit modulo.
  - count compared unsigned.
- Bytes arriving while rx_ready=0 are not consumed; the upstream holds them.

## Timing
- Reset values:
  - State HDR.
  - rx_ready=1 immediately after reset release.
  - InstrWrite=0, WriteInst=0, WriteAdress=BASE_ADDR, done=0, err=0, core_reset=1.
- Word latency:
  - 4th byte accepted at edge N → InstrWrite high from N to N+1, with WriteInst/WriteAdress stable in that cycle.
  - Next byte is accepted no earlier than edge N+2.
  - Peak throughput: one word per 5 cycles.
- WriteInst/WriteAdress are registered and hold their last value outside WRITE.
- Completion: DONE is entered one edge after the last WRITE, or one edge after the checksum byte. core_reset falls and done rises in that same cycle.
- rx_valid gaps of any length in HDR/DATA/CHK stall without state change.
- Asynchronous reset mid-load: outputs are at reset values immediately; partial word discarded; load restarts from count_lo.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - CHK state present.
  - Running XOR covers both count bytes and all data bytes.
  - Mismatch → ERR; core never released.
- Undefined:
  - No CHK state, no checksum byte expected.
  - The last WRITE, or count==0, goes directly to DONE.

## Structure
- Shared package loader_pkg: state enum (HDR, DATA, WRITE, CHK, DONE, ERR), HDR_BYTES=2, WORD_BYTES=4.
- One sub-module word_packer holds the 4-byte little-endian shift register with byte counter and a word-complete flag. The FSM, address generation and checksum stay in imem_loader.

## Test plan
- count=2, bytes 02 00 93 00 50 00 13 01 10 00 (+C3 with macro) → InstrWrite at 0x0 with 0x00500093, then at 0x4 with 0x00100113; done=1, core_reset=0; with the macro, checksum byte 0xC4 → err=1, core_reset=1.
- Bytes 00 00 (+00 with macro) → no InstrWrite; DONE reached.
- MAX_WORDS=64, bytes 41 00 → ERR right after the second byte, rx_ready=0, no writes.
- Same image as the first scenario, with rx_valid low for 3 cycles between every byte → identical writes, no dropped or duplicated bytes; rx_ready=0 during every WRITE cycle.
- Reset asserted after 6 bytes → outputs at reset values; the full image is then resent and loads correctly from 0x0.
- In DONE, pulse reload, then send count=1, bytes 13 00 00 00 → core_reset rises, write 0x00000013 at BASE_ADDR, done again.
